// File: rtl/pe_row_sequencer.sv
// pe_row_sequencer
//   Feed and control stage in front of one PE. It loads one ifmap row (W words)
//   and one filter row (S words) into the PE scratchpads. It then runs the 1-D
//   row convolution as a CLR / (MAC, WB) x S loop for each of the E = W-S+1
//   outputs. Each finished psum is emitted on a valid/ready stream.
//
// Ports
//   clk, rst                 clock; synchronous active-high reset
//   start, cfg_w, cfg_s      job launch and row width / filter length
//   busy, done, cfg_err      job status; done/cfg_err are one-cycle pulses
//   if_*, flt_*              ifmap / filter input streams (valid/ready/data)
//   ps_*                     output psum stream (valid/ready/data)
//   pe_*                     PE scratchpad addresses, write strobes, data, MAC enable
//   pe_output_psum           PE registered accumulator (valid the cycle after pe_en)
//
// Build option
//   PE_PSUM_PRELOAD_EN: adds the ips_* input-psum stream. When it is set, CLR
//   waits for an ips handshake and preloads the psum pad entry with ips_data
//   instead of zero.
module pe_row_sequencer #(
  parameter int unsigned DW        = 16,
  parameter int unsigned IF_DEPTH  = 12,
  parameter int unsigned FLT_DEPTH = 224,
  parameter int unsigned PS_DEPTH  = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [3:0]    cfg_w,
  input  logic [7:0]    cfg_s,
  output logic          busy,
  output logic          done,
  output logic          cfg_err,
  input  logic          if_valid,
  output logic          if_ready,
  input  logic [DW-1:0] if_data,
  input  logic          flt_valid,
  output logic          flt_ready,
  input  logic [DW-1:0] flt_data,
`ifdef PE_PSUM_PRELOAD_EN
  input  logic          ips_valid,
  output logic          ips_ready,
  input  logic [DW-1:0] ips_data,
`endif
  output logic          ps_valid,
  input  logic          ps_ready,
  output logic [DW-1:0] ps_data,
  output logic          pe_en,
  output logic [3:0]    pe_addr_ifmap,
  output logic [7:0]    pe_addr_filter,
  output logic [4:0]    pe_addr_psum,
  output logic          pe_wr_en_ifmap,
  output logic          pe_wr_en_filter,
  output logic          pe_wr_en_psum,
  output logic [DW-1:0] pe_input_ifmap,
  output logic [DW-1:0] pe_input_filter,
  output logic [DW-1:0] pe_input_psum,
  input  logic [DW-1:0] pe_output_psum
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_IF, S_LOAD_FLT, S_CLR, S_MAC, S_WB, S_OUT
  } state_t;

  localparam logic [3:0] IF_MAX  = 4'(IF_DEPTH);
  localparam logic [7:0] FLT_MAX = 8'(FLT_DEPTH);
  localparam logic [8:0] PS_MAX  = 9'(PS_DEPTH);

  state_t          state_q, state_d;
  logic [3:0]      w_q, w_d;          // row width W
  logic [7:0]      slen_q, slen_d;    // filter length S
  logic [3:0]      elast_q, elast_d;  // E-1 = W-S
  logic [7:0]      ld_q, ld_d;        // load word index (ifmap then filter)
  logic [3:0]      e_q, e_d;          // output index
  logic [7:0]      s_q, s_d;          // tap index
  logic [DW-1:0]   ps_data_q, ps_data_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            cfg_bad;

  // The last clause (E > PS_DEPTH) cannot trigger with default depths. It keeps
  // the psum pad safe if the depths are ever re-parameterised.
  assign cfg_bad = (cfg_s == 8'd0) || (cfg_w == 4'd0) || (cfg_w > IF_MAX) ||
                   ({4'b0, cfg_w} < cfg_s) || (cfg_s > FLT_MAX) ||
                   ({5'b0, cfg_w} >= ({1'b0, cfg_s} + PS_MAX));

  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign cfg_err = err_q;
  assign ps_data = ps_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      w_q       <= '0;
      slen_q    <= '0;
      elast_q   <= '0;
      ld_q      <= '0;
      e_q       <= '0;
      s_q       <= '0;
      ps_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      w_q       <= w_d;
      slen_q    <= slen_d;
      elast_q   <= elast_d;
      ld_q      <= ld_d;
      e_q       <= e_d;
      s_q       <= s_d;
      ps_data_q <= ps_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    w_d             = w_q;
    slen_d          = slen_q;
    elast_d         = elast_q;
    ld_d            = ld_q;
    e_d             = e_q;
    s_d             = s_q;
    ps_data_d       = ps_data_q;
    done_d          = 1'b0;
    err_d           = 1'b0;
    if_ready        = 1'b0;
    flt_ready       = 1'b0;
    ps_valid        = 1'b0;
    pe_en           = 1'b0;
    pe_addr_ifmap   = '0;
    pe_addr_filter  = '0;
    pe_addr_psum    = '0;
    pe_wr_en_ifmap  = 1'b0;
    pe_wr_en_filter = 1'b0;
    pe_wr_en_psum   = 1'b0;
    pe_input_ifmap  = '0;
    pe_input_filter = '0;
    pe_input_psum   = '0;
`ifdef PE_PSUM_PRELOAD_EN
    ips_ready       = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_bad) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            w_d     = cfg_w;
            slen_d  = cfg_s;
            elast_d = cfg_w - cfg_s[3:0];  // S <= W <= 12 once legal
            ld_d    = '0;
            state_d = S_LOAD_IF;
          end
        end
      end
      S_LOAD_IF: begin
        if_ready       = 1'b1;
        pe_addr_ifmap  = ld_q[3:0];
        pe_input_ifmap = if_data;
        if (if_valid) begin
          pe_wr_en_ifmap = 1'b1;
          if (ld_q == ({4'b0, w_q} - 8'd1)) begin
            ld_d    = '0;
            state_d = S_LOAD_FLT;
          end else begin
            ld_d = ld_q + 8'd1;
          end
        end
      end
      S_LOAD_FLT: begin
        flt_ready       = 1'b1;
        pe_addr_filter  = ld_q;
        pe_input_filter = flt_data;
        if (flt_valid) begin
          pe_wr_en_filter = 1'b1;
          if (ld_q == (slen_q - 8'd1)) begin
            ld_d    = '0;
            e_d     = '0;
            state_d = S_CLR;
          end else begin
            ld_d = ld_q + 8'd1;
          end
        end
      end
      S_CLR: begin
        pe_addr_psum = {1'b0, e_q};
`ifdef PE_PSUM_PRELOAD_EN
        ips_ready     = 1'b1;
        pe_input_psum = ips_data;
        if (ips_valid) begin
          pe_wr_en_psum = 1'b1;
          s_d           = '0;
          state_d       = S_MAC;
        end
`else
        pe_wr_en_psum = 1'b1;
        s_d           = '0;
        state_d       = S_MAC;
`endif
      end
      S_MAC: begin
        pe_en          = 1'b1;
        pe_addr_ifmap  = e_q + s_q[3:0];
        pe_addr_filter = s_q;
        pe_addr_psum   = {1'b0, e_q};
        state_d        = S_WB;
      end
      S_WB: begin
        pe_wr_en_psum = 1'b1;
        pe_addr_psum  = {1'b0, e_q};
        pe_input_psum = pe_output_psum;
        if (s_q == (slen_q - 8'd1)) begin
          ps_data_d = pe_output_psum;
          state_d   = S_OUT;
        end else begin
          s_d     = s_q + 8'd1;
          state_d = S_MAC;
        end
      end
      S_OUT: begin
        ps_valid = 1'b1;
        if (ps_ready) begin
          if (e_q == elast_q) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            e_d     = e_q + 4'd1;
            state_d = S_CLR;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
